// File: rtl/circuito_exp_5.sv
// -----------------------------------------------------------------------------
// circuito_exp_5 - sequence-memory game core (Genius-style)
//
// The core plays a fixed 16-step sequence stored in an internal ROM. Play is in
// rounds: round k asks the player to repeat steps 0..k on the four buttons.
// Finishing round 16 correctly wins the game. A wrong press loses it, and so
// does a play timeout when that feature is built in.
//
// Build option:
//   TIMEOUT_EN - when defined, a 13-bit timeout counter runs while the FSM
//                waits for a play. If TIMEOUT cycles pass with no press, the
//                game ends in fim_timeout. When it is not defined there is no
//                timeout logic, db_timeout is tied to 0, and the FSM waits for
//                a play indefinitely.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   jogar          in   start/restart request (level)
//   botoes[3:0]    in   player buttons, one-hot expected
//   ganhou         out  game won (held in the final state)
//   perdeu         out  game lost, by wrong press or by timeout (held)
//   pronto         out  game over (either outcome)
//   leds[3:0]      out  last registered play
//   db_igual       out  registered play == ROM[address]
//   db_timeout     out  in the timeout final state
//   db_contagem    out  7-seg (active-low, gfedcba) of the address counter
//   db_memoria     out  7-seg of ROM[address]
//   db_estado      out  7-seg of the FSM state code
//   db_jogadafeita out  7-seg of the registered play
//   db_clock       out  copy of clock
//   db_iniciar     out  copy of jogar
//   db_tem_jogada  out  one-cycle pulse on a detected press
// -----------------------------------------------------------------------------
module circuito_exp_5
`ifdef TIMEOUT_EN
    #(parameter int TIMEOUT = 5000)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic       db_timeout,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    // Each enum value is also the hex digit shown on db_estado.
    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_inicia_rodada  = 4'h2,
        st_espera_jogada  = 4'h3,
        st_registra       = 4'h4,
        st_compara        = 4'h5,
        st_proxima_jogada = 4'h6,
        st_proxima_rodada = 4'h8,
        st_fim_ganhou     = 4'hA,
        st_fim_timeout    = 4'hD,
        st_fim_perdeu     = 4'hE
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] e_q, e_d;            // address counter (step within the round)
    logic [3:0] l_q, l_d;            // round limit
    logic [3:0] jogada_q, jogada_d;  // registered play, also drives leds
    logic       botao_q, botao_d;    // OR of the buttons, one cycle ago
    logic       tem_jogada;
    logic [3:0] rom_dado;
    logic       igual;
`ifdef TIMEOUT_EN
    logic [12:0] t_q, t_d;
`endif

    function automatic logic [3:0] rom(input logic [3:0] a);
        case (a)
            4'd0:  rom = 4'b0001;
            4'd1:  rom = 4'b0010;
            4'd2:  rom = 4'b0100;
            4'd3:  rom = 4'b1000;
            4'd4:  rom = 4'b0100;
            4'd5:  rom = 4'b0010;
            4'd6:  rom = 4'b0001;
            4'd7:  rom = 4'b0001;
            4'd8:  rom = 4'b0010;
            4'd9:  rom = 4'b0010;
            4'd10: rom = 4'b0100;
            4'd11: rom = 4'b0100;
            4'd12: rom = 4'b1000;
            4'd13: rom = 4'b1000;
            4'd14: rom = 4'b0001;
            default: rom = 4'b0100;
        endcase
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Only the rising edge of "any button down" counts as a press, so a held
    // button is a single play and the next play needs a release first.
    assign botao_d    = |botoes;
    assign tem_jogada = botao_d & ~botao_q;
    assign rom_dado   = rom(e_q);
    assign igual      = (jogada_q == rom_dado);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= st_inicial;
            e_q      <= 4'd0;
            l_q      <= 4'd0;
            jogada_q <= 4'd0;
            botao_q  <= 1'b0;
`ifdef TIMEOUT_EN
            t_q      <= 13'd0;
`endif
        end else begin
            estado_q <= estado_d;
            e_q      <= e_d;
            l_q      <= l_d;
            jogada_q <= jogada_d;
            botao_q  <= botao_d;
`ifdef TIMEOUT_EN
            t_q      <= t_d;
`endif
        end
    end

    always_comb begin
        estado_d = estado_q;
        e_d      = e_q;
        l_d      = l_q;
        jogada_d = jogada_q;
`ifdef TIMEOUT_EN
        t_d      = 13'd0;    // the timer only runs while waiting for a play
`endif
        case (estado_q)
            st_inicial: begin
                if (jogar) estado_d = st_preparacao;
            end
            st_preparacao: begin
                e_d      = 4'd0;
                l_d      = 4'd0;
                jogada_d = 4'd0;
                estado_d = st_inicia_rodada;
            end
            st_inicia_rodada: begin
                e_d      = 4'd0;
                estado_d = st_espera_jogada;
            end
            st_espera_jogada: begin
                if (tem_jogada) begin
                    estado_d = st_registra;
`ifdef TIMEOUT_EN
                end else if (t_q == 13'(TIMEOUT - 1)) begin
                    estado_d = st_fim_timeout;
                end else begin
                    t_d = t_q + 13'd1;
`endif
                end
            end
            st_registra: begin
                jogada_d = botoes;
                estado_d = st_compara;
            end
            st_compara: begin
                // e_q never exceeds l_q, so "not equal" means "still inside the round".
                if (!igual)             estado_d = st_fim_perdeu;
                else if (e_q != l_q)    estado_d = st_proxima_jogada;
                else if (l_q != 4'hF)   estado_d = st_proxima_rodada;
                else                    estado_d = st_fim_ganhou;
            end
            st_proxima_jogada: begin
                e_d      = e_q + 4'd1;
                estado_d = st_espera_jogada;
            end
            st_proxima_rodada: begin
                l_d      = l_q + 4'd1;
                e_d      = 4'd0;
                estado_d = st_espera_jogada;
            end
            st_fim_ganhou, st_fim_perdeu, st_fim_timeout: begin
                if (jogar) estado_d = st_preparacao;
            end
            default: estado_d = st_inicial;
        endcase
    end

    always_comb begin
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        pronto     = 1'b0;
        db_timeout = 1'b0;
        case (estado_q)
            st_fim_ganhou: begin
                ganhou = 1'b1;
                pronto = 1'b1;
            end
            st_fim_perdeu: begin
                perdeu = 1'b1;
                pronto = 1'b1;
            end
            st_fim_timeout: begin
                perdeu     = 1'b1;
                pronto     = 1'b1;
`ifdef TIMEOUT_EN
                db_timeout = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign leds           = jogada_q;
    assign db_igual       = igual;
    assign db_contagem    = hex7(e_q);
    assign db_memoria     = hex7(rom_dado);
    assign db_estado      = hex7(estado_q);
    assign db_jogadafeita = hex7(jogada_q);
    assign db_clock       = clock;
    assign db_iniciar     = jogar;
    assign db_tem_jogada  = tem_jogada;

endmodule

// File: tb/tb_circuito_exp_5.sv
// -----------------------------------------------------------------------------
// tb_circuito_exp_5 - directed testbench for circuito_exp_5.
// Covers reset state, a full winning game, restart after a win, a losing
// game, asynchronous reset in the middle of a game, and the play timeout
// (its expected outcome follows TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_circuito_exp_5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic       ganhou, perdeu, pronto, db_igual, db_timeout;
    logic       db_clock, db_iniciar, db_tem_jogada;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rom_m [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                               4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};

    circuito_exp_5 dut (
        .clock          (clock),
        .reset          (reset),
        .jogar          (jogar),
        .botoes         (botoes),
        .ganhou         (ganhou),
        .perdeu         (perdeu),
        .pronto         (pronto),
        .leds           (leds),
        .db_igual       (db_igual),
        .db_timeout     (db_timeout),
        .db_contagem    (db_contagem),
        .db_memoria     (db_memoria),
        .db_estado      (db_estado),
        .db_jogadafeita (db_jogadafeita),
        .db_clock       (db_clock),
        .db_iniciar     (db_iniciar),
        .db_tem_jogada  (db_tem_jogada)
    );

    always #5 clock = ~clock;

    // Segment pattern for a hex digit: build the lit-segment (active-high)
    // pattern in gfedcba order, then invert it for the active-low display.
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] hi;
        case (v)
            4'h0: hi = 7'h3F;
            4'h1: hi = 7'h06;
            4'h2: hi = 7'h5B;
            4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;
            4'h5: hi = 7'h6D;
            4'h6: hi = 7'h7D;
            4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;
            4'h9: hi = 7'h6F;
            4'hA: hi = 7'h77;
            4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;
            4'hD: hi = 7'h5E;
            4'hE: hi = 7'h79;
            default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One play: hold 10 cycles, release 10 cycles.
    task automatic press(input logic [3:0] b);
        botoes = b;
        tick(10);
        botoes = 4'b0000;
        tick(10);
    endtask

    task automatic play_round(input int k);
        for (int i = 0; i <= k; i++) press(rom_m[i]);
    endtask

    task automatic start_game();
        jogar = 1'b1;
        tick(1);
        jogar = 1'b0;
        tick(2);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(1);
        reset = 1'b1;
        tick(15);
        chk("reset_estado", 16'(db_estado), 16'(seg(4'h0)));
        chk("reset_ganhou", 16'(ganhou), 16'd0);
        chk("reset_perdeu", 16'(perdeu), 16'd0);
        chk("reset_pronto", 16'(pronto), 16'd0);
        chk("reset_timeout", 16'(db_timeout), 16'd0);
        chk("reset_leds", 16'(leds), 16'd0);
        chk("reset_contagem", 16'(db_contagem), 16'(seg(4'h0)));
        chk("reset_jogadafeita", 16'(db_jogadafeita), 16'(seg(4'h0)));
        chk("reset_memoria", 16'(db_memoria), 16'(seg(4'h1)));
        chk("reset_igual", 16'(db_igual), 16'd0);

        // ---------------- start, jogar held 5 cycles ----------------
        jogar = 1'b1;
        tick(1);
        chk("start_preparacao", 16'(db_estado), 16'(seg(4'h1)));
        chk("start_iniciar", 16'(db_iniciar), 16'd1);
        tick(4);
        jogar = 1'b0;
        chk("start_espera", 16'(db_estado), 16'(seg(4'h3)));

        // ---------------- first press, latency ----------------
        botoes = 4'b0001;
        #1;
        chk("press_pulse", 16'(db_tem_jogada), 16'd1);
        tick(1);
        chk("press_registra", 16'(db_estado), 16'(seg(4'h4)));
        chk("press_pulse_once", 16'(db_tem_jogada), 16'd0);
        chk("press_leds_not_yet", 16'(leds), 16'd0);
        tick(1);
        chk("press_compara", 16'(db_estado), 16'(seg(4'h5)));
        chk("press_leds", 16'(leds), 16'b0001);
        chk("press_jogadafeita", 16'(db_jogadafeita), 16'(seg(4'h1)));
        chk("press_igual", 16'(db_igual), 16'd1);
        tick(1);
        chk("press_prox_rodada", 16'(db_estado), 16'(seg(4'h8)));
        tick(1);
        chk("press_back_espera", 16'(db_estado), 16'(seg(4'h3)));
        chk("press_e_zero", 16'(db_contagem), 16'(seg(4'h0)));
        tick(6);
        botoes = 4'b0000;
        tick(10);

        // ---------------- rounds 2..16, win ----------------
        for (int k = 1; k <= 15; k++) play_round(k);
        chk("win_ganhou", 16'(ganhou), 16'd1);
        chk("win_pronto", 16'(pronto), 16'd1);
        chk("win_perdeu", 16'(perdeu), 16'd0);
        chk("win_estado", 16'(db_estado), 16'(seg(4'hA)));
        chk("win_contagem", 16'(db_contagem), 16'(seg(4'hF)));
        chk("win_leds", 16'(leds), 16'b0100);
        tick(20);
        chk("win_held", 16'(db_estado), 16'(seg(4'hA)));

        // ---------------- restart after win ----------------
        jogar = 1'b1;
        tick(1);
        jogar = 1'b0;
        chk("restart_estado", 16'(db_estado), 16'(seg(4'h1)));
        chk("restart_ganhou", 16'(ganhou), 16'd0);
        chk("restart_pronto", 16'(pronto), 16'd0);
        tick(2);
        chk("restart_espera", 16'(db_estado), 16'(seg(4'h3)));
        chk("restart_leds", 16'(leds), 16'd0);
        press(4'b0001);
        chk("restart_r1_estado", 16'(db_estado), 16'(seg(4'h3)));
        chk("restart_r1_perdeu", 16'(perdeu), 16'd0);
        chk("restart_r1_e", 16'(db_contagem), 16'(seg(4'h0)));

        // ---------------- loss: round 2 ok, wrong press in round 3 ----------------
        press(4'b0001);
        chk("r2_step1_e", 16'(db_contagem), 16'(seg(4'h1)));
        press(4'b0010);
        press(4'b1000);
        chk("lose_perdeu", 16'(perdeu), 16'd1);
        chk("lose_pronto", 16'(pronto), 16'd1);
        chk("lose_ganhou", 16'(ganhou), 16'd0);
        chk("lose_estado", 16'(db_estado), 16'(seg(4'hE)));
        chk("lose_igual", 16'(db_igual), 16'd0);
        chk("lose_leds", 16'(leds), 16'b1000);

        // ---------------- reset mid round 5 ----------------
        start_game();
        for (int k = 0; k <= 3; k++) play_round(k);
        press(rom_m[0]);
        press(rom_m[1]);
        chk("mid_e_two", 16'(db_contagem), 16'(seg(4'h2)));
        chk("mid_memoria", 16'(db_memoria), 16'(seg(4'h4)));
        reset = 1'b0;
        #1;
        chk("mid_reset_estado", 16'(db_estado), 16'(seg(4'h0)));
        chk("mid_reset_leds", 16'(leds), 16'd0);
        chk("mid_reset_contagem", 16'(db_contagem), 16'(seg(4'h0)));
        chk("mid_reset_jogadafeita", 16'(db_jogadafeita), 16'(seg(4'h0)));
        chk("mid_reset_memoria", 16'(db_memoria), 16'(seg(4'h1)));
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("mid_idle_inicial", 16'(db_estado), 16'(seg(4'h0)));
        start_game();
        press(4'b0001);
        chk("mid_restart_e", 16'(db_contagem), 16'(seg(4'h0)));
        chk("mid_restart_estado", 16'(db_estado), 16'(seg(4'h3)));

        // ---------------- play timeout ----------------
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        jogar = 1'b1;
        tick(1);
        jogar = 1'b0;
        tick(2);
        chk("to_espera", 16'(db_estado), 16'(seg(4'h3)));
        tick(4999);
        chk("to_before_edge", 16'(db_estado), 16'(seg(4'h3)));
        tick(1);
`ifdef TIMEOUT_EN
        chk("to_estado", 16'(db_estado), 16'(seg(4'hD)));
        chk("to_flag", 16'(db_timeout), 16'd1);
        chk("to_perdeu", 16'(perdeu), 16'd1);
        chk("to_pronto", 16'(pronto), 16'd1);
        tick(10);
        chk("to_held", 16'(db_estado), 16'(seg(4'hD)));
`else
        chk("no_to_estado", 16'(db_estado), 16'(seg(4'h3)));
        chk("no_to_flag", 16'(db_timeout), 16'd0);
        chk("no_to_perdeu", 16'(perdeu), 16'd0);
        tick(10);
        chk("no_to_held", 16'(db_estado), 16'(seg(4'h3)));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
